cdc_hs_sender: RTL and testbench

Source-side controller for a four-phase REQ/ACK clock-domain crossing on the AXI4Bus fabric. It accepts words from a local valid/ready stream, launches each across the crossing with a registered REQ, holds data stable for the whole handshake, and sequences completion on the destination's ACK, which it synchronizes through a `SyncLine` instance. A one-entry pending buffer lets the next word be accepted while a handshake is in flight.

---
 rtl/cdc_hs_sender_pkg.sv | 23 ++
 rtl/cdc_hs_sender_syncline.sv | 25 ++
 rtl/cdc_hs_sender.sv | 119 +++++++++++
 tb/tb_cdc_hs_sender.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_sender_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | cdc_pkg : shared types and helpers for the REQ/ACK source sender   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package cdc_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ_HI   = 2'd1,
      ACK_WAIT = 2'd2
   } state_t;

   // Phase-timer width; never narrower than one bit so TIMEOUT=0 still elaborates.
   function automatic int timeout_width(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_hs_sender_syncline.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | SyncLine : plain multi-flop synchronizer, no reset                 |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module SyncLine #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             CLK,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   logic [STAGES*WIDTH-1:0] r_sync;

   always_ff @(posedge CLK) begin
      r_sync <= {r_sync[(STAGES-1)*WIDTH-1:0], D};
   end

   assign Q = r_sync[STAGES*WIDTH-1 -: WIDTH];

endmodule
`default_nettype wire

// File: rtl/cdc_hs_sender.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | cdc_hs_sender : source side of a four-phase REQ/ACK crossing with  |
// |                 a one-word pending buffer and optional timeout     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module cdc_hs_sender
   import cdc_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int STAGES  = 2,
   parameter int TIMEOUT = 0
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             S_VALID,
   output logic             S_READY,
   input  logic [WIDTH-1:0] S_DATA,
   output logic             REQ,
   output logic [WIDTH-1:0] DATA_OUT,
   input  logic             ACK,
   output logic             BUSY,
   output logic             ERR
);

   localparam int            CW        = timeout_width(TIMEOUT);
   localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);

   state_t           r_state;
   logic             r_pend_v;
   logic [WIDTH-1:0] r_pend_data;
   logic [CW-1:0]    r_cnt;

   logic             w_ack_s;
   logic             w_xfer;
   logic             w_have_next;
   logic [WIDTH-1:0] w_next_data;
   logic             w_launch;
   logic             w_enter;
   logic [CW-1:0]    w_cnt_inc;

   SyncLine #(
      .WIDTH  (1),
      .STAGES (STAGES)
   ) u_ack_sync (
      .CLK (CLK),
      .D   (ACK),
      .Q   (w_ack_s)
   );

   assign S_READY     = !r_pend_v;
   assign w_xfer      = S_VALID && S_READY;
   assign w_have_next = r_pend_v || w_xfer;
   assign w_next_data = r_pend_v ? r_pend_data : S_DATA;

   // A launch needs the previous handshake fully returned to zero on the far side.
   assign w_launch = w_have_next && !w_ack_s &&
                     ((r_state == IDLE) || (r_state == ACK_WAIT));

   assign w_enter  = ((r_state == IDLE)     && w_have_next && !w_ack_s) ||
                     ((r_state == REQ_HI)   && w_ack_s)                 ||
                     ((r_state == ACK_WAIT) && !w_ack_s);

   assign w_cnt_inc = r_cnt + CW'(1);

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_state     <= IDLE;
         REQ         <= 1'b0;
         DATA_OUT    <= '0;
         r_pend_v    <= 1'b0;
         r_pend_data <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_launch) r_state <= REQ_HI;
            end
            REQ_HI: begin
               if (w_ack_s) begin
                  REQ     <= 1'b0;
                  r_state <= ACK_WAIT;
               end
            end
            ACK_WAIT: begin
               if (!w_ack_s) r_state <= w_have_next ? REQ_HI : IDLE;
            end
            default: r_state <= IDLE;
         endcase

         // Launch takes priority over buffering, so a word arriving on the
         // completing edge goes straight out and the pend slot stays empty.
         if (w_launch) begin
            REQ      <= 1'b1;
            DATA_OUT <= w_next_data;
            if (r_pend_v) r_pend_v <= 1'b0;
         end else if (w_xfer) begin
            r_pend_v    <= 1'b1;
            r_pend_data <= S_DATA;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_cnt <= '0;
         ERR   <= 1'b0;
      end else if (w_enter) begin
         r_cnt <= '0;
      end else if (((r_state == REQ_HI) || (r_state == ACK_WAIT)) && (r_cnt != C_TIMEOUT)) begin
         r_cnt <= w_cnt_inc;
         if ((TIMEOUT != 0) && (w_cnt_inc == C_TIMEOUT)) ERR <= 1'b1;
      end
   end

   assign BUSY = (r_state != IDLE) || r_pend_v;

endmodule
`default_nettype wire

// File: tb/tb_cdc_hs_sender.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cdc_hs_sender : scoreboard bench for the REQ/ACK source sender  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_cdc_hs_sender;

   localparam int WIDTH   = 32;
   localparam int STAGES  = 2;
   localparam int TIMEOUT = 16;

   logic             CLK     = 1'b0;
   logic             RESETn  = 1'b0;
   logic             S_VALID = 1'b0;
   logic [WIDTH-1:0] S_DATA  = '0;
   logic             S_READY;
   logic             REQ;
   logic [WIDTH-1:0] DATA_OUT;
   logic             ACK;
   logic             BUSY;
   logic             ERR;

   logic resp_en  = 1'b0;
   logic resp_ack = 1'b0;
   logic man_ack  = 1'b0;
   assign ACK = resp_en ? resp_ack : man_ack;

   int n_checks = 0;
   int n_errors = 0;
   int n_launch = 0;

   logic [31:0] sb_q[$];
   logic        mon_en    = 1'b0;
   logic        prev_req  = 1'b0;
   logic        prev_ack  = 1'b0;
   logic [31:0] prev_data = '0;

   always #5 CLK = ~CLK;

   cdc_hs_sender #(
      .WIDTH   (WIDTH),
      .STAGES  (STAGES),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .CLK      (CLK),
      .RESETn   (RESETn),
      .S_VALID  (S_VALID),
      .S_READY  (S_READY),
      .S_DATA   (S_DATA),
      .REQ      (REQ),
      .DATA_OUT (DATA_OUT),
      .ACK      (ACK),
      .BUSY     (BUSY),
      .ERR      (ERR)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Pops the scoreboard on each REQ rise and guards DATA_OUT during a handshake.
   always @(negedge CLK) begin
      if (mon_en) begin
         if (REQ && !prev_req) begin
            n_launch++;
            check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) check("launch_data", DATA_OUT, sb_q.pop_front());
         end else if (prev_req || prev_ack) begin
            check("data_stable", DATA_OUT, prev_data);
         end
      end
      prev_req  = REQ;
      prev_ack  = ACK;
      prev_data = DATA_OUT;
   end

   // Destination model: ack 3 cycles after REQ, release 3 cycles after REQ drops.
   initial begin
      forever begin
         @(negedge CLK);
         if (resp_en && REQ && !resp_ack) begin
            int g;
            repeat (3) @(posedge CLK);
            #1 resp_ack = 1'b1;
            g = 0;
            while (REQ && g < 300) begin
               @(negedge CLK);
               g++;
            end
            check("resp_req_fall", 32'(REQ), 32'd0);
            repeat (3) @(posedge CLK);
            #1 resp_ack = 1'b0;
         end
      end
   end

   task automatic send_word(input logic [31:0] d, output int stall);
      int guard;
      guard   = 0;
      stall   = 0;
      S_VALID = 1'b1;
      S_DATA  = d;
      @(negedge CLK);
      while (!S_READY && guard < 500) begin
         stall++;
         guard++;
         @(negedge CLK);
      end
      check("send_accept", 32'(S_READY), 32'd1);
      if (S_READY) sb_q.push_back(d);
      @(posedge CLK);
      #1;
      S_VALID = 1'b0;
   endtask

   task automatic wait_req(input logic val, input string tag);
      int g;
      g = 0;
      while (REQ !== val && g < 300) begin
         @(posedge CLK);
         #1;
         g++;
      end
      check(tag, 32'(REQ), 32'(val));
   endtask

   task automatic wait_idle(input string tag);
      int g;
      g = 0;
      while (BUSY && g < 300) begin
         @(posedge CLK);
         #1;
         g++;
      end
      check(tag, 32'(BUSY), 32'd0);
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      #2 RESETn = 1'b0;
      #4 RESETn = 1'b1;
      sb_q.delete();
      @(posedge CLK);
      #1;
      mon_en = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int base;

      // Reset state
      #2;
      check("rst_req",    32'(REQ),     32'd0);
      check("rst_data",   DATA_OUT,     32'd0);
      check("rst_busy",   32'(BUSY),    32'd0);
      check("rst_err",    32'(ERR),     32'd0);
      check("rst_sready", 32'(S_READY), 32'd1);
      @(posedge CLK);
      @(posedge CLK);
      #1 RESETn = 1'b1;
      @(posedge CLK);
      #1 mon_en = 1'b1;

      // Single word with precise ACK timing
      send_word(32'hDEADBEEF, st);
      check("sw_req_rise", 32'(REQ), 32'd1);
      check("sw_data",     DATA_OUT, 32'hDEADBEEF);
      repeat (3) @(posedge CLK);
      #1 man_ack = 1'b1;
      @(posedge CLK); #1 check("sw_req_e1", 32'(REQ), 32'd1);
      @(posedge CLK); #1 check("sw_req_e2", 32'(REQ), 32'd1);
      @(posedge CLK); #1 check("sw_req_e3", 32'(REQ), 32'd0);
      repeat (3) @(posedge CLK);
      #1 man_ack = 1'b0;
      @(posedge CLK); #1 check("sw_busy_f1", 32'(BUSY), 32'd1);
      @(posedge CLK); #1 check("sw_busy_f2", 32'(BUSY), 32'd1);
      @(posedge CLK); #1 check("sw_busy_f3", 32'(BUSY), 32'd0);
      check("sw_err", 32'(ERR), 32'd0);

      // Back-to-back with the auto responder
      resp_en = 1'b1;
      base = n_launch;
      send_word(32'h1, st);
      send_word(32'h2, st);
      check("bb_sready_low", 32'(S_READY), 32'd0);
      check("bb_busy",       32'(BUSY),    32'd1);
      send_word(32'h3, st);
      check("bb_w3_stalled", 32'(st > 0),  32'd1);
      wait_idle("bb_idle");
      check("bb_launches", 32'(n_launch - base), 32'd3);
      check("bb_sb_empty", 32'(sb_q.size()),     32'd0);
      check("bb_err",      32'(ERR),             32'd0);
      resp_en = 1'b0;

      // Timeout with ACK held low, then a late ACK
      do_reset();
      send_word(32'hA5A50001, st);
      repeat (15) @(posedge CLK);
      #1 check("to_err_pre", 32'(ERR), 32'd0);
      @(posedge CLK);
      #1 check("to_err_set", 32'(ERR), 32'd1);
      check("to_req_held", 32'(REQ), 32'd1);
      repeat (10) @(posedge CLK);
      #1 check("to_req_still", 32'(REQ), 32'd1);
      man_ack = 1'b1;
      wait_req(1'b0, "to_req_fall");
      check("to_err_sticky", 32'(ERR), 32'd1);
      #1 man_ack = 1'b0;
      wait_idle("to_idle");
      check("to_err_end", 32'(ERR), 32'd1);

      // Reset while ACK is high; next word must wait in pend
      do_reset();
      check("rr_err_clr", 32'(ERR), 32'd0);
      send_word(32'h77, st);
      check("rr_req_pre", 32'(REQ), 32'd1);
      man_ack = 1'b1;
      mon_en  = 1'b0;
      #2 RESETn = 1'b0;
      #1;
      check("rr_req_async",  32'(REQ),  32'd0);
      check("rr_data_async", DATA_OUT,  32'd0);
      check("rr_busy_async", 32'(BUSY), 32'd0);
      #1 RESETn = 1'b1;
      sb_q.delete();
      repeat (4) @(posedge CLK);
      #1 mon_en = 1'b1;
      send_word(32'h55, st);
      check("rr_busy_pend", 32'(BUSY),    32'd1);
      check("rr_req_held",  32'(REQ),     32'd0);
      check("rr_sready",    32'(S_READY), 32'd0);
      repeat (4) @(posedge CLK);
      #1 check("rr_req_wait", 32'(REQ), 32'd0);
      man_ack = 1'b0;
      @(posedge CLK); #1 check("rr_req_f1", 32'(REQ), 32'd0);
      @(posedge CLK); #1 check("rr_req_f2", 32'(REQ), 32'd0);
      @(posedge CLK); #1 check("rr_req_f3", 32'(REQ), 32'd1);
      check("rr_data", DATA_OUT, 32'h55);
      man_ack = 1'b1;
      wait_req(1'b0, "rr_req_fall");
      #1 man_ack = 1'b0;
      wait_idle("rr_idle");

      repeat (2) @(posedge CLK);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
